// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: R-type funct codes, ALU op encodings and MDU state.
// Pure definitions, no logic; imported by the decoder and the multiply/divide unit.
package mips_pkg;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

    localparam logic [5:0] FUNCT6_SLL   = 6'h00;
    localparam logic [5:0] FUNCT6_SRL   = 6'h02;
    localparam logic [5:0] FUNCT6_SRA   = 6'h03;
    localparam logic [5:0] FUNCT6_JR    = 6'h08;
    localparam logic [5:0] FUNCT6_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT6_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT6_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT6_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT6_MULT  = 6'h18;
    localparam logic [5:0] FUNCT6_MULTU = 6'h19;
    localparam logic [5:0] FUNCT6_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT6_DIVU  = 6'h1B;
    localparam logic [5:0] FUNCT6_ADD   = 6'h20;
    localparam logic [5:0] FUNCT6_ADDU  = 6'h21;
    localparam logic [5:0] FUNCT6_SUB   = 6'h22;
    localparam logic [5:0] FUNCT6_SUBU  = 6'h23;
    localparam logic [5:0] FUNCT6_AND   = 6'h24;
    localparam logic [5:0] FUNCT6_OR    = 6'h25;
    localparam logic [5:0] FUNCT6_XOR   = 6'h26;
    localparam logic [5:0] FUNCT6_NOR   = 6'h27;
    localparam logic [5:0] FUNCT6_SLT   = 6'h2A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

    function automatic logic is_mdu_funct(input logic [5:0] f);
        return f inside {FUNCT6_MFHI, FUNCT6_MTHI, FUNCT6_MFLO, FUNCT6_MTLO,
                         FUNCT6_MULT, FUNCT6_MULTU, FUNCT6_DIV, FUNCT6_DIVU};
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide step.
// Purely combinational, zero latency; no handshake.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] sreg,
    input  logic [WIDTH-1:0] mag,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] sreg_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        sum    = {1'b0, acc} + (sreg[0] ? {1'b0, mag} : '0);
        rem_sh = {acc, sreg[WIDTH-1]};
        ge     = rem_sh >= {1'b0, mag};
        // remainder stays below the divisor, so the subtraction fits in WIDTH bits
        diff   = rem_sh[WIDTH-1:0] - mag;
        if (is_div) begin
            acc_next  = ge ? diff : rem_sh[WIDTH-1:0];
            sreg_next = {sreg[WIDTH-2:0], ge};
        end else begin
            acc_next  = sum[WIDTH:1];
            sreg_next = {sum[0], sreg[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Iterative MIPS multiply/divide unit with HI/LO; WIDTH+1 busy cycles per mul/div.
// Holds the pipeline through stall while busy; divide-by-zero reports done+dbz one edge later.
module mdu_seq
    import mips_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int FUNCT_W = 6
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [1:0]         alu_op_i2,
    input  logic [FUNCT_W-1:0] funct_i6,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               stall_o,
    output logic               done_o,
    output logic               dbz_o,
    output logic [WIDTH-1:0]   rd_data_o,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mdu_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc, sreg, mag, acc_next, sreg_next;
    logic [WIDTH-1:0] hi, lo;
    logic             is_div, neg_q, neg_r, dbz_pend, done, dbz;

    logic [5:0]       f6;
    logic             rtype, known, accept, mul_op, div_op, signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_fix;

    assign f6        = funct_i6[5:0];
    assign rtype     = alu_op_i2 == ALU_OP_RTYPE;
    assign known     = is_mdu_funct(f6);
    assign busy_o    = state != IDLE;
    assign accept    = start_i && rtype && known && !busy_o;
    assign stall_o   = start_i && rtype && known && busy_o;
    assign mul_op    = f6 == FUNCT6_MULT || f6 == FUNCT6_MULTU;
    assign div_op    = f6 == FUNCT6_DIV  || f6 == FUNCT6_DIVU;
    assign signed_op = f6 == FUNCT6_MULT || f6 == FUNCT6_DIV;
    assign a_neg     = signed_op && a_i[WIDTH-1];
    assign b_neg     = signed_op && b_i[WIDTH-1];
    assign a_mag     = a_neg ? -a_i : a_i;
    assign b_mag     = b_neg ? -b_i : b_i;
    assign prod_fix  = neg_q ? -{acc, sreg} : {acc, sreg};

    assign done_o = done;
    assign dbz_o  = dbz;
    assign hi_o   = hi;
    assign lo_o   = lo;

    always_comb begin
        rd_data_o = '0;
        if (rtype && f6 == FUNCT6_MFHI)
            rd_data_o = hi;
        else if (rtype && f6 == FUNCT6_MFLO)
            rd_data_o = lo;
    end

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div    (is_div),
        .acc       (acc),
        .sreg      (sreg),
        .mag       (mag),
        .acc_next  (acc_next),
        .sreg_next (sreg_next)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            sreg     <= '0;
            mag      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            dbz      <= 1'b0;
            dbz_pend <= 1'b0;
        end else begin
            done     <= dbz_pend;
            dbz      <= dbz_pend;
            dbz_pend <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (f6 == FUNCT6_MTHI) begin
                            hi <= a_i;
                        end else if (f6 == FUNCT6_MTLO) begin
                            lo <= a_i;
                        end else if (div_op && b_i == '0) begin
                            dbz_pend <= 1'b1;
                        end else if (mul_op || div_op) begin
                            // multiply shifts the multiplier through sreg; divide shifts the dividend
                            state  <= RUN;
                            cnt    <= '0;
                            acc    <= '0;
                            sreg   <= div_op ? a_mag : b_mag;
                            mag    <= div_op ? b_mag : a_mag;
                            is_div <= div_op;
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                        end
                    end
                end
                RUN: begin
                    acc  <= acc_next;
                    sreg <= sreg_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        lo <= neg_q ? -sreg : sreg;
                        hi <= neg_r ? -acc : acc;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: directed scenarios plus random ops vs. an arithmetic model.
module tb_mdu_seq;
    import mips_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [1:0]    alu_op;
    logic [5:0]    funct;
    logic [W-1:0]  a, b;
    logic          busy_o, stall_o, done_o, dbz_o;
    logic [W-1:0]  rd_data_o, hi_o, lo_o;

    typedef struct {
        logic         dbz;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t         sb[$];
    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always #5 clk = ~clk;

    mdu_seq #(.WIDTH(W), .FUNCT_W(6)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .alu_op_i2 (alu_op),
        .funct_i6  (funct),
        .a_i       (a),
        .b_i       (b),
        .busy_o    (busy_o),
        .stall_o   (stall_o),
        .done_o    (done_o),
        .dbz_o     (dbz_o),
        .rd_data_o (rd_data_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Reference: HI/LO effect of one accepted instruction, from plain 64-bit arithmetic.
    task automatic drive_op(input logic [1:0] op, input logic [5:0] f,
                            input logic [W-1:0] av, input logic [W-1:0] bv);
        longint      sa, sbv, q, r;
        logic [63:0] p, qv, rv;
        logic        is_md;
        start  = 1'b1;
        alu_op = op;
        funct  = f;
        a      = av;
        b      = bv;
        sa     = longint'($signed(av));
        sbv    = longint'($signed(bv));
        is_md  = 1'b0;
        p      = '0;
        if (op == ALU_OP_RTYPE) begin
            case (f)
                FUNCT6_MTHI:  m_hi = av;
                FUNCT6_MTLO:  m_lo = av;
                FUNCT6_MULT:  begin p = sa * sbv; is_md = 1'b1; end
                FUNCT6_MULTU: begin p = {32'b0, av} * {32'b0, bv}; is_md = 1'b1; end
                FUNCT6_DIV, FUNCT6_DIVU: begin
                    if (bv == 0) begin
                        sb.push_back('{1'b1, m_hi, m_lo});
                    end else begin
                        if (f == FUNCT6_DIV) begin
                            q = sa / sbv; r = sa % sbv;
                            qv = q; rv = r;
                        end else begin
                            qv = {32'b0, av / bv}; rv = {32'b0, av % bv};
                        end
                        p = {rv[31:0], qv[31:0]};
                        is_md = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (is_md) begin
            m_hi = p[63:32];
            m_lo = p[31:0];
            sb.push_back('{1'b0, m_hi, m_lo});
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [5:0] f,
                         input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        drive_op(op, f, av, bv);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_quiet();
        for (int i = 0; i < 200 && (busy_o || sb.size() != 0); i++)
            @(negedge clk);
        check("quiet_timeout", 32'(busy_o || sb.size() != 0), 32'd0);
    endtask

    function automatic logic [W-1:0] rnd();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        int   run;
        exp_t e;
        run = 0;
        forever begin
            @(negedge clk);
            if (done_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 required no outstanding op");
                end else begin
                    e = sb.pop_front();
                    check("done_hi", hi_o, e.hi);
                    check("done_lo", lo_o, e.lo);
                    check("done_dbz", 32'(dbz_o), 32'(e.dbz));
                    check("busy_cycles", 32'(run), e.dbz ? 32'd0 : 32'(W + 1));
                end
                run = 0;
            end else if (busy_o) begin
                run++;
            end else begin
                run = 0;
            end
        end
    end

    initial begin
        logic [5:0] fl [6];
        int         n;
        fl = '{FUNCT6_MULT, FUNCT6_MULTU, FUNCT6_DIV, FUNCT6_DIVU, FUNCT6_MTHI, FUNCT6_MTLO};
        rst = 1'b1; start = 1'b0; alu_op = 2'b00; funct = 6'h0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_dbz", 32'(dbz_o), 32'd0);
        check("rst_hi", hi_o, 32'h0);
        check("rst_lo", lo_o, 32'h0);
        rst = 1'b0;

        issue(ALU_OP_RTYPE, FUNCT6_MULT, 32'hFFFF_FFFE, 32'd3);
        wait_quiet();
        check("mult_hi", hi_o, 32'hFFFF_FFFF);
        check("mult_lo", lo_o, 32'hFFFF_FFFA);

        // MULTU, then DIV issued in the done cycle
        issue(ALU_OP_RTYPE, FUNCT6_MULTU, 32'hFFFF_FFFE, 32'd3);
        for (int i = 0; i < 60 && !done_o; i++) @(negedge clk);
        check("multu_done", 32'(done_o), 32'd1);
        check("multu_hi", hi_o, 32'h0000_0002);
        check("multu_lo", lo_o, 32'hFFFF_FFFA);
        drive_op(ALU_OP_RTYPE, FUNCT6_DIV, 32'hFFFF_FFF9, 32'd2);
        @(negedge clk);
        start = 1'b0;
        check("b2b_accept", 32'(busy_o), 32'd1);
        wait_quiet();
        check("div_lo", lo_o, 32'hFFFF_FFFD);
        check("div_hi", hi_o, 32'hFFFF_FFFF);

        issue(ALU_OP_RTYPE, FUNCT6_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_quiet();
        check("ovf_lo", lo_o, 32'h8000_0000);
        check("ovf_hi", hi_o, 32'h0);

        issue(ALU_OP_RTYPE, FUNCT6_DIVU, 32'd5, 32'd0);
        check("dbz_early", 32'(done_o), 32'd0);
        check("dbz_nobusy", 32'(busy_o), 32'd0);
        @(negedge clk);
        check("dbz_done", 32'(done_o), 32'd1);
        check("dbz_flag", 32'(dbz_o), 32'd1);
        check("dbz_hi", hi_o, 32'h0);
        check("dbz_lo", lo_o, 32'h8000_0000);
        wait_quiet();

        // MFLO held during a MULT
        @(negedge clk);
        drive_op(ALU_OP_RTYPE, FUNCT6_MULT, 32'd7, 32'hFFFF_FFF7);
        @(negedge clk);
        funct = FUNCT6_MFLO;
        n = 0;
        while (busy_o && n < 60) begin
            #1;
            check("stall_busy", 32'(stall_o), 32'd1);
            n++;
            @(negedge clk);
        end
        #1;
        check("stall_done_pulse", 32'(done_o), 32'd1);
        check("stall_released", 32'(stall_o), 32'd0);
        check("mflo_data", rd_data_o, 32'hFFFF_FFC1);
        funct = FUNCT6_MFHI;
        #1;
        check("mfhi_data", rd_data_o, m_hi);
        start = 1'b0;
        wait_quiet();

        // non-MDU instruction while busy
        @(negedge clk);
        drive_op(ALU_OP_RTYPE, FUNCT6_MULTU, 32'd3, 32'd5);
        @(negedge clk);
        funct = FUNCT6_ADD;
        #1;
        check("add_no_stall", 32'(stall_o), 32'd0);
        check("add_busy", 32'(busy_o), 32'd1);
        start = 1'b0;
        wait_quiet();

        issue(2'b00, FUNCT6_MULT, 32'd3, 32'd4);
        check("aluop_ignored", 32'(busy_o), 32'd0);
        issue(ALU_OP_RTYPE, FUNCT6_ADD, 32'd3, 32'd4);
        check("funct_ignored", 32'(busy_o), 32'd0);
        check("ignored_lo", lo_o, m_lo);

        // reset in the middle of a MULT
        @(negedge clk);
        drive_op(ALU_OP_RTYPE, FUNCT6_MULT, 32'd12345, 32'd678);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        m_hi = '0;
        m_lo = '0;
        #1;
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_hi", hi_o, 32'h0);
        check("midrst_lo", lo_o, 32'h0);
        repeat (45) @(negedge clk);
        issue(ALU_OP_RTYPE, FUNCT6_MTHI, 32'h1234, 32'd0);
        check("mthi", hi_o, 32'h1234);
        check("mthi_nobusy", 32'(busy_o), 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic [5:0]   rf;
            rf = fl[$urandom_range(0, 5)];
            ra = rnd();
            rb = ($urandom_range(0, 5) == 0) ? 32'h0 : rnd();
            issue(ALU_OP_RTYPE, rf, ra, rb);
            wait_quiet();
            check("rand_hi", hi_o, m_hi);
            check("rand_lo", lo_o, m_lo);
        end

        repeat (5) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
